// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : wb_pkg                                                    |
// | Shared widths and source encodings for the writeback port arbiter.  |
// | Revision: 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package wb_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  // Encoding of grant_src / last_grant.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Writes to the hardwired-zero register are consumed but never reach the RF.
  function automatic logic is_zero_reg(input logic [REG_W-1:0] rd);
    return (rd == ZERO_REG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : wb_port_arbiter_if                                      |
// | Bundles the two writeback requesters, the RF stall input and the    |
// | registered RF write port.                                           |
// |   master : requester / RF side (drives valids, payloads, rf_stall)  |
// |   slave  : arbiter side (drives readies, rf_we/waddr/wdata, grant)  |
// | Revision: 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              rf_stall;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              grant_src;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output rf_stall,
    input  alu_ready, mem_ready,
    input  rf_we, rf_waddr, rf_wdata, grant_src
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  rf_stall,
    output alu_ready, mem_ready,
    output rf_we, rf_waddr, rf_wdata, grant_src
  );

endinterface
`default_nettype wire

// File: rtl/wb_arb_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : wb_arb_core                                               |
// | Grant decision between ALU and MEM writeback requests.              |
// |   clk, reset          : clock, async active-high reset              |
// |   alu_valid/mem_valid : request inputs                              |
// |   rf_stall            : RF cannot accept a write; blocks all grants |
// |   alu_ready/mem_ready : combinational accept, at most one high      |
// |   fire, fire_src      : a request is accepted and from which source |
// | Build option WB_RR_EN : round-robin on ties instead of MEM priority |
// |                         with ALU starvation guard.                  |
// | Revision: 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module wb_arb_core #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic mem_valid,
  input  logic rf_stall,
  output logic alu_ready,
  output logic mem_ready,
  output logic fire,
  output logic fire_src
);
  import wb_pkg::*;

  logic alu_wins;
  logic accept;

`ifdef WB_RR_EN
  // Round-robin: on a tie the source that did not win last time goes next.
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    alu_wins     = alu_valid & (~mem_valid | (last_grant_q == SRC_MEM));
    last_grant_d = last_grant_q;
    if (fire) begin
      last_grant_d = fire_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: MEM wins ties until ALU has waited STARVE_LIMIT cycles.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  always_comb begin
    alu_wins   = alu_valid & (~mem_valid | (wait_cnt_q == LIMIT));
    wait_cnt_d = wait_cnt_q;
    if (!alu_valid || alu_ready) begin
      wait_cnt_d = '0;
    end else if (!rf_stall && (wait_cnt_q != LIMIT)) begin
      // Stalled cycles are not counted as lost: the counter freezes.
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // Nothing is accepted while the RF stalls or while reset is asserted, so
  // requests held through reset are re-arbitrated after release.
  always_comb begin
    accept    = ~rf_stall & ~reset;
    alu_ready = alu_wins & accept;
    mem_ready = mem_valid & ~alu_wins & accept;
    fire      = alu_ready | mem_ready;
    fire_src  = mem_ready ? SRC_MEM : SRC_ALU;
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : wb_port_arbiter                                           |
// | Shares the single register-file write port between the ALU result   |
// | path and the memory-load path; the winner is registered onto the    |
// | RF write port one cycle after it is accepted.                       |
// |   clk   : clock, rising edge                                        |
// |   reset : asynchronous active-high reset                            |
// |   bus   : wb_port_arbiter_if.slave (requests, readies, RF port)     |
// | Build option WB_RR_EN : round-robin arbitration (see wb_arb_core).  |
// | Revision: 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  wb_port_arbiter_if.slave   bus
);
  import wb_pkg::*;

  logic fire;
  logic fire_src;

  wb_arb_core #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (bus.alu_valid),
    .mem_valid (bus.mem_valid),
    .rf_stall  (bus.rf_stall),
    .alu_ready (bus.alu_ready),
    .mem_ready (bus.mem_ready),
    .fire      (fire),
    .fire_src  (fire_src)
  );

  logic [REG_W-1:0]  sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_q,     rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q,  rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;
  logic              grant_src_q, grant_src_d;

  always_comb begin
    sel_rd   = (fire_src == SRC_MEM) ? bus.mem_rd   : bus.alu_rd;
    sel_data = (fire_src == SRC_MEM) ? bus.mem_data : bus.alu_data;

    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    grant_src_d = grant_src_q;

    if (fire) begin
      grant_src_d = fire_src;
      if (is_zero_reg(sel_rd)) begin
        // Consumed without a write; the port shows an all-zero idle beat.
        rf_waddr_d = ZERO_REG;
        rf_wdata_d = '0;
      end else begin
        rf_we_d    = 1'b1;
        rf_waddr_d = sel_rd;
        rf_wdata_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      grant_src_q <= SRC_ALU;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      grant_src_q <= grant_src_d;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.grant_src = grant_src_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_wb_port_arbiter                                        |
// | Self-checking bench for wb_port_arbiter: directed vector table,     |
// | fire-order / stall / mid-stream reset sequences, and randomized     |
// | traffic against a behavioural model. Honours WB_RR_EN.              |
// | Revision: 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_wb_port_arbiter;
  import wb_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;

  logic clk;
  logic reset;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
`ifdef WB_RR_EN
  logic        m_last;
`else
  int          m_wait;
`endif
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_gsrc;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        st;
    logic        e_ar;
    logic        e_mr;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_gsrc;
  } vec_t;

  vec_t       vt [8];
  logic [1:0] ord_exp [10];
  logic [1:0] stl_exp [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic st);
    bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv;  bus.mem_rd = mrd; bus.mem_data = md;
    bus.rf_stall  = st;
  endtask

  task automatic model_reset();
`ifdef WB_RR_EN
    m_last  = SRC_ALU;
`else
    m_wait  = 0;
`endif
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_gsrc  = 1'b0;
  endtask

  // Holds reset over one edge with no requests; checks the cleared state.
  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_we",    bus.rf_we,     0);
    chk("rst_waddr", bus.rf_waddr,  0);
    chk("rst_wdata", bus.rf_wdata,  0);
    chk("rst_gsrc",  bus.grant_src, 0);
    chk("rst_ardy",  bus.alu_ready, 0);
    chk("rst_mrdy",  bus.mem_ready, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  // Returns {alu_ready,mem_ready} from the DUT and from the model.
  task automatic run_cycle(output logic [1:0] dut_g, output logic [1:0] exp_g);
    logic        ap, mp, ea, em;
    logic [4:0]  rd;
    logic [31:0] d;
    #3;
`ifdef WB_RR_EN
    ap = bus.alu_valid && (!bus.mem_valid || m_last == SRC_MEM);
`else
    ap = bus.alu_valid && (!bus.mem_valid || m_wait >= STARVE_LIMIT);
`endif
    mp = bus.mem_valid && !ap;
    ea = ap && !bus.rf_stall;
    em = mp && !bus.rf_stall;
    chk("alu_ready", bus.alu_ready, ea);
    chk("mem_ready", bus.mem_ready, em);
    dut_g = {bus.alu_ready, bus.mem_ready};
    exp_g = {ea, em};

    m_we = 1'b0;
    if (ea || em) begin
      rd     = em ? bus.mem_rd   : bus.alu_rd;
      d      = em ? bus.mem_data : bus.alu_data;
      m_gsrc = em;
`ifdef WB_RR_EN
      m_last = em;
`endif
      if (rd == 5'd0) begin
        m_waddr = '0;
        m_wdata = '0;
      end else begin
        m_we    = 1'b1;
        m_waddr = rd;
        m_wdata = d;
      end
    end
`ifndef WB_RR_EN
    if (!bus.alu_valid || ea) m_wait = 0;
    else if (!bus.rf_stall && m_wait < STARVE_LIMIT) m_wait++;
`endif

    @(posedge clk); #1;
    chk("rf_we",     bus.rf_we,     m_we);
    chk("rf_waddr",  bus.rf_waddr,  m_waddr);
    chk("rf_wdata",  bus.rf_wdata,  m_wdata);
    chk("grant_src", bus.grant_src, m_gsrc);
  endtask

  logic [1:0]  dg, eg;
  logic        a_v, m_v, st, a_pend, m_pend;
  logic [4:0]  a_rd, m_rd;
  logic [31:0] a_d, m_d;

  initial begin
    //                 av  ard   ad            mv  mrd   md            st  ar mr we waddr  wdata         g
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h00001234, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        1'b1};
    vt[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1};
    vt[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b1};
    vt[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  32'hA5A5A5A5, 1'b1};
    vt[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  32'hA5A5A5A5, 1'b1};
    vt[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
    vt[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 1'b0};

    // 2'b10 = ALU accepted, 2'b01 = MEM accepted, 2'b00 = nothing accepted.
`ifdef WB_RR_EN
    ord_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    stl_exp = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
`else
    ord_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    stl_exp = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
`endif

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Directed vector table, one cycle per entry.
    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].av, vt[i].ard, vt[i].ad, vt[i].mv, vt[i].mrd, vt[i].md, vt[i].st);
      #3;
      chk("tbl_ardy", bus.alu_ready, vt[i].e_ar);
      chk("tbl_mrdy", bus.mem_ready, vt[i].e_mr);
      @(posedge clk); #1;
      chk("tbl_we",    bus.rf_we,     vt[i].e_we);
      chk("tbl_waddr", bus.rf_waddr,  vt[i].e_waddr);
      chk("tbl_wdata", bus.rf_wdata,  vt[i].e_wdata);
      chk("tbl_gsrc",  bus.grant_src, vt[i].e_gsrc);
    end

    // Both requesters continuously valid, same destination register.
    do_reset();
    set_in(1, 5'd4, 32'h0000AAAA, 1, 5'd4, 32'h0000BBBB, 0);
    for (int i = 0; i < 10; i++) begin
      run_cycle(dg, eg);
      chk("fire_order", dg, ord_exp[i]);
    end

    // Stall for three cycles in the middle of a contended stream.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 5'd1, 32'h11110000 + i, 1, 5'd2, 32'h22220000 + i, (i >= 2 && i <= 4));
      run_cycle(dg, eg);
      chk("stall_order", dg, stl_exp[i]);
    end

    // Asynchronous reset between edges while a write is on the port.
    do_reset();
    set_in(1, 5'd9, 32'hCAFEF00D, 0, 0, 0, 0);
    run_cycle(dg, eg);
    chk("pre_rst_we", bus.rf_we, 1);
    #1;
    set_in(1, 5'd10, 32'h0BADF00D, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("async_we",    bus.rf_we,     0);
    chk("async_waddr", bus.rf_waddr,  0);
    chk("async_wdata", bus.rf_wdata,  0);
    chk("async_gsrc",  bus.grant_src, 0);
    chk("async_ardy",  bus.alu_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    run_cycle(dg, eg);
    chk("post_rst_waddr", bus.rf_waddr, 10);
    set_in(0, 0, 0, 0, 0, 0, 0);
    run_cycle(dg, eg);

    // Randomized traffic; a pending request keeps its payload until accepted.
    do_reset();
    a_pend = 1'b0; m_pend = 1'b0;
    a_v = 1'b0; m_v = 1'b0; a_rd = '0; m_rd = '0; a_d = '0; m_d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!a_pend) begin
        a_v  = ($urandom_range(0, 99) < 65);
        a_rd = 5'($urandom_range(0, 7));
        a_d  = $urandom;
      end
      if (!m_pend) begin
        m_v  = ($urandom_range(0, 99) < 65);
        m_rd = 5'($urandom_range(0, 7));
        m_d  = $urandom;
      end
      st = ($urandom_range(0, 99) < 20);
      set_in(a_v, a_rd, a_d, m_v, m_rd, m_d, st);
      run_cycle(dg, eg);
      a_pend = a_v && !eg[1];
      m_pend = m_v && !eg[0];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
